// File: rtl/csm_pkg.sv
// csm_pkg: shared FSM state type, default widths and nibble count for the coefficient sequencer
package csm_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int CSM_COEF_WIDTH = 16;
  localparam int CSM_BASE_WIDTH = 21;
  localparam int CSM_TIMEOUT = 8;
  localparam int NIBBLES = CSM_COEF_WIDTH / 4;
endpackage

// File: rtl/csm_nibble_accum.sv
// csm_nibble_accum: shift-and-accumulate of base-block partial products, negated on read
// Ports: clk/reset; i_clr clears; i_add adds i_data << 4*i_shift; i_neg selects -acc on o_acc.
module csm_nibble_accum
  import csm_pkg::*;
#(
  parameter int BASE_WIDTH = CSM_BASE_WIDTH,
  parameter int ACC_WIDTH = CSM_BASE_WIDTH + CSM_COEF_WIDTH,
  parameter int KW = 2
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clr,
  input  logic                  i_add,
  input  logic [KW-1:0]         i_shift,
  input  logic [BASE_WIDTH-1:0] i_data,
  input  logic                  i_neg,
  output logic [ACC_WIDTH-1:0]  o_acc
);
  logic [ACC_WIDTH-1:0] r_acc;
  always_ff @(posedge clk)
    if (reset || i_clr) r_acc <= '0;
    else if (i_add) r_acc <= r_acc + (ACC_WIDTH'(i_data) << {i_shift, 2'b00});
  assign o_acc = i_neg ? -r_acc : r_acc;
endmodule

// File: rtl/csm_coeff_sequencer.sv
// csm_coeff_sequencer: walks a coefficient nibble by nibble through a shared base block and accumulates a signed product
// Ports: coef_in_vld/rdy/coef_in/coef_sign request; polynomial/base_req_vld to base block;
//        base_data/base_data_vld from base block; prod_out/prod_vld/prod_rdy result; busy, err_timeout status.
module csm_coeff_sequencer
  import csm_pkg::*;
#(
  parameter int COEF_WIDTH = CSM_COEF_WIDTH,
  parameter int BASE_WIDTH = CSM_BASE_WIDTH,
  parameter int ACC_WIDTH = BASE_WIDTH + COEF_WIDTH,
  parameter int TIMEOUT = CSM_TIMEOUT
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  coef_in_vld,
  output logic                  coef_in_rdy,
  input  logic [COEF_WIDTH-1:0] coef_in,
  input  logic                  coef_sign,
  output logic [3:0]            polynomial,
  output logic                  base_req_vld,
  input  logic [BASE_WIDTH-1:0] base_data,
  input  logic                  base_data_vld,
  output logic [ACC_WIDTH-1:0]  prod_out,
  output logic                  prod_vld,
  input  logic                  prod_rdy,
  output logic                  busy,
  output logic                  err_timeout
);
  localparam int NIB = COEF_WIDTH / 4;
  localparam int KW = NIB > 1 ? $clog2(NIB) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t r_state, w_next;
  logic [COEF_WIDTH-1:0] r_coef;
  logic r_sign;
  logic [KW-1:0] r_k, w_skip_k;
  logic [CW-1:0] r_cnt;
  logic [3:0] w_nib;
  logic w_last, w_skip_any, w_accept, w_add, w_tmo;
  logic [ACC_WIDTH-1:0] w_acc;
  assign w_nib = r_coef[{r_k, 2'b00} +: 4];
  assign w_last = r_k == KW'(NIB - 1);
  assign w_accept = r_state == IDLE && coef_in_vld;
  // Lowest nonzero nibble above k, so runs of zero nibbles cost one cycle total
  always_comb begin
    w_skip_any = 1'b0;
    w_skip_k = r_k;
    for (int j = NIB - 1; j >= 0; j--)
      if (j > int'(r_k) && r_coef[4*j +: 4] != 4'd0) begin
        w_skip_any = 1'b1;
        w_skip_k = KW'(j);
      end
  end
  always_comb begin
    w_next = r_state;
    w_add = 1'b0;
    w_tmo = 1'b0;
    case (r_state)
      IDLE:  w_next = coef_in_vld ? ISSUE : IDLE;
      ISSUE: w_next = w_nib != 4'd0 ? WAIT : (w_skip_any ? ISSUE : DONE);
      WAIT:
        if (base_data_vld) begin
          w_add = 1'b1;
          w_next = w_last ? DONE : ISSUE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_tmo = 1'b1;
          w_next = IDLE;
        end
      DONE:  w_next = prod_rdy ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_coef <= '0;
      r_sign <= 1'b0;
      r_k <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= r_state == WAIT ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_coef <= coef_in;
        r_sign <= coef_sign;
        r_k <= '0;
      end else if (r_state == ISSUE && w_nib == 4'd0 && w_skip_any) r_k <= w_skip_k;
      else if (w_add && !w_last) r_k <= r_k + 1'b1;
    end
  csm_nibble_accum #(.BASE_WIDTH(BASE_WIDTH), .ACC_WIDTH(ACC_WIDTH), .KW(KW)) u_accum (
    .clk(clk),
    .reset(reset),
    .i_clr(w_accept || w_tmo),
    .i_add(w_add),
    .i_shift(r_k),
    .i_data(base_data),
    .i_neg(r_sign),
    .o_acc(w_acc)
  );
  assign coef_in_rdy = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign base_req_vld = r_state == ISSUE && w_nib != 4'd0;
  assign polynomial = base_req_vld ? w_nib : 4'd0;
  assign prod_vld = r_state == DONE;
  assign prod_out = prod_vld ? w_acc : '0;
  assign err_timeout = w_tmo;
endmodule

// File: tb/tb_csm_coeff_sequencer.sv
// tb_csm_coeff_sequencer: directed bench with a 3*polynomial base-block model
module tb_csm_coeff_sequencer;
  localparam int CW = 16;
  localparam int BW = 21;
  localparam int AW = 37;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coef_in_vld = 1'b0;
  logic coef_in_rdy;
  logic [CW-1:0] coef_in = '0;
  logic coef_sign = 1'b0;
  logic [3:0] polynomial;
  logic base_req_vld;
  logic [BW-1:0] base_data;
  logic base_data_vld;
  logic [AW-1:0] prod_out;
  logic prod_vld;
  logic prod_rdy = 1'b0;
  logic busy;
  logic err_timeout;
  int n_cmp = 0;
  int n_err = 0;
  logic model_on = 1'b1;
  logic p1_vld = 1'b0, p2_vld = 1'b0, m_vld = 1'b0;
  logic [BW-1:0] p1_d = '0, p2_d = '0, m_d = '0;
  logic tb_vld = 1'b0;
  logic [BW-1:0] tb_d = '0;
  int req_cnt = 0;
  logic [3:0] polys [0:15];
  assign base_data_vld = m_vld | tb_vld;
  assign base_data = tb_vld ? tb_d : m_d;
  always #5 clk = ~clk;
  csm_coeff_sequencer dut (
    .clk(clk), .reset(reset), .coef_in_vld(coef_in_vld), .coef_in_rdy(coef_in_rdy),
    .coef_in(coef_in), .coef_sign(coef_sign), .polynomial(polynomial), .base_req_vld(base_req_vld),
    .base_data(base_data), .base_data_vld(base_data_vld), .prod_out(prod_out), .prod_vld(prod_vld),
    .prod_rdy(prod_rdy), .busy(busy), .err_timeout(err_timeout)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Base-block model: answers 3*polynomial two cycles after each request
  always @(negedge clk) begin
    m_vld = p2_vld;
    m_d = p2_d;
    p2_vld = p1_vld;
    p2_d = p1_d;
    p1_vld = model_on && base_req_vld;
    p1_d = BW'(3 * polynomial);
    if (base_req_vld) begin
      if (req_cnt < 16) polys[req_cnt] = polynomial;
      req_cnt++;
    end else check("poly_zero", 64'(polynomial), 64'd0);
  end
  task automatic accept(input logic [CW-1:0] c, input logic s);
    @(negedge clk);
    coef_in = c;
    coef_sign = s;
    coef_in_vld = 1'b1;
    @(posedge clk);
    #1 coef_in_vld = 1'b0;
  endtask
  task automatic wait_prod(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!prod_vld && cyc < 100);
  endtask
  task automatic release_prod();
    prod_rdy = 1'b1;
    @(posedge clk);
    #1 prod_rdy = 1'b0;
  endtask
  task automatic check_reset_outs(input string tag);
    check({tag, "_rdy"}, 64'(coef_in_rdy), 64'd1);
    check({tag, "_req"}, 64'(base_req_vld), 64'd0);
    check({tag, "_poly"}, 64'(polynomial), 64'd0);
    check({tag, "_pvld"}, 64'(prod_vld), 64'd0);
    check({tag, "_pout"}, 64'(prod_out), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_tmo"}, 64'(err_timeout), 64'd0);
  endtask
  initial begin
    int cyc, tmo_n, tmo_at, pv_n;
    logic [AW-1:0] held, neg;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("rst");
    reset = 1'b0;
    req_cnt = 0;
    accept(16'h1234, 1'b0);
    wait_prod(cyc);
    check("t1_vld", 64'(prod_vld), 64'd1);
    check("t1_prod", 64'(prod_out), 64'd13980);
    check("t1_reqs", 64'(req_cnt), 64'd4);
    check("t1_p0", 64'(polys[0]), 64'd4);
    check("t1_p1", 64'(polys[1]), 64'd3);
    check("t1_p2", 64'(polys[2]), 64'd2);
    check("t1_p3", 64'(polys[3]), 64'd1);
    held = prod_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_hold", 64'(prod_out), 64'(held));
      check("t1_hold_vld", 64'(prod_vld), 64'd1);
      check("t1_hold_rdy", 64'(coef_in_rdy), 64'd0);
    end
    release_prod();
    @(negedge clk);
    check("t1_idle", 64'(coef_in_rdy), 64'd1);
    req_cnt = 0;
    accept(16'h0000, 1'b0);
    wait_prod(cyc);
    check("t2_vld", 64'(prod_vld), 64'd1);
    check("t2_lat", 64'(cyc), 64'd2);
    check("t2_prod", 64'(prod_out), 64'd0);
    check("t2_reqs", 64'(req_cnt), 64'd0);
    release_prod();
    req_cnt = 0;
    neg = -AW'(64'd11520);
    accept(16'h0F00, 1'b1);
    wait_prod(cyc);
    check("t3_vld", 64'(prod_vld), 64'd1);
    check("t3_reqs", 64'(req_cnt), 64'd1);
    check("t3_p0", 64'(polys[0]), 64'hF);
    check("t3_prod", 64'(prod_out), 64'(neg));
    release_prod();
    model_on = 1'b0;
    req_cnt = 0;
    tmo_n = 0;
    tmo_at = 0;
    pv_n = 0;
    accept(16'h0001, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        tmo_n++;
        tmo_at = i;
      end
      if (prod_vld) pv_n++;
    end
    check("t4_tmo_cnt", 64'(tmo_n), 64'd1);
    check("t4_tmo_at", 64'(tmo_at), 64'd9);
    check("t4_no_prod", 64'(pv_n), 64'd0);
    check("t4_reqs", 64'(req_cnt), 64'd1);
    check("t4_idle", 64'(coef_in_rdy), 64'd1);
    accept(16'h0010, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outs("t5");
    tb_d = BW'(5);
    tb_vld = 1'b1;
    @(posedge clk);
    #1 tb_vld = 1'b0;
    @(negedge clk);
    check("t5_late_rdy", 64'(coef_in_rdy), 64'd1);
    check("t5_late_pvld", 64'(prod_vld), 64'd0);
    check("t5_late_busy", 64'(busy), 64'd0);
    model_on = 1'b1;
    neg = -AW'(64'd6);
    accept(16'h0002, 1'b1);
    wait_prod(cyc);
    check("t6_vld", 64'(prod_vld), 64'd1);
    check("t6_prod", 64'(prod_out), 64'(neg));
    release_prod();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
